// File: rtl/mau_pkg.sv
// Shared types and defaults for the memory access unit.
// Command codes, sequencer states and stack defaults.
package mau_pkg;

   typedef enum logic [2:0] {
      OP_LOAD  = 3'd0,
      OP_STORE = 3'd1,
      OP_PUSH  = 3'd2,
      OP_POP   = 3'd3,
      OP_COPY  = 3'd4
   } op_t;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_EXEC  = 3'd1,
      S_CP_RD = 3'd2,
      S_CP_WR = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   localparam logic [7:0] STACK_BASE_DEF = 8'hC0;
   localparam logic [7:0] SP_RESET_DEF   = 8'hFF;

   function automatic logic op_defined(
      input logic [2:0] code
   );
      return code <= 3'd4;
   endfunction

endpackage

// File: rtl/mau_sp_ctrl.sv
// Stack pointer register with full/empty detection.
// The stack grows downward from SP_RESET toward STACK_BASE.
module mau_sp_ctrl
   import mau_pkg::*;
#(
   parameter logic [7:0] STACK_BASE = STACK_BASE_DEF,
   parameter logic [7:0] SP_RESET   = SP_RESET_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push_en,
   input  logic       pop_en,
   output logic [7:0] sp,
   output logic       full,
   output logic       empty
);

   assign full  = (sp < STACK_BASE);
   assign empty = (sp == SP_RESET);

   // Move sp only for accepted pushes/pops.
   always_ff @(posedge clk) begin
      if (reset) begin
         sp <= SP_RESET;
      end else if (push_en && !full) begin
         sp <= sp - 8'd1;
      end else if (pop_en && !empty) begin
         sp <= sp + 8'd1;
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access sequencer: LOAD/STORE, PUSH/POP, COPY.
// Sole driver of the data memory address/write ports.
module mem_access_unit
   import mau_pkg::*;
#(
   parameter logic [7:0] STACK_BASE = STACK_BASE_DEF,
   parameter logic [7:0] SP_RESET   = SP_RESET_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] op,
   input  logic [7:0] addr,
   input  logic [7:0] src,
   input  logic [7:0] len,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [7:0] rdata,
   output logic [7:0] sp,
   output logic [7:0] mem_addr,
   output logic       mem_wr_en,
   output logic [7:0] mem_dat_in,
   input  logic [7:0] mem_dat_out
);

   state_t     state;
   state_t     state_n;
   op_t        op_q;
   logic [7:0] addr_q;
   logic [7:0] wdata_q;
   logic [7:0] src_ptr;
   logic [7:0] dst_ptr;
   logic [7:0] cnt;
   logic [7:0] cbuf_q;
   logic       err_q;
   logic       full;
   logic       empty;
   logic       push_req;
   logic       pop_req;

   assign push_req = (state == S_EXEC)
                   && (op_q == OP_PUSH);
   assign pop_req  = (state == S_EXEC)
                   && (op_q == OP_POP);

   mau_sp_ctrl #(
      .STACK_BASE (STACK_BASE),
      .SP_RESET   (SP_RESET)
   ) u_sp (
      .clk     (clk),
      .reset   (reset),
      .push_en (push_req),
      .pop_en  (pop_req),
      .sp      (sp),
      .full    (full),
      .empty   (empty)
   );

   assign busy = (state == S_EXEC)
              || (state == S_CP_RD)
              || (state == S_CP_WR);
   assign done = (state == S_FIN);
   assign err  = done && err_q;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state decode; start is only seen in IDLE.
   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               if (!op_defined(op)) begin
                  state_n = S_FIN;
               end else if (op == OP_COPY) begin
                  if (len == 8'd0) begin
                     state_n = S_FIN;
                  end else begin
                     state_n = S_CP_RD;
                  end
               end else begin
                  state_n = S_EXEC;
               end
            end
         end
         S_EXEC:  state_n = S_FIN;
         S_CP_RD: state_n = S_CP_WR;
         S_CP_WR: begin
            if (cnt == 8'd1) begin
               state_n = S_FIN;
            end else begin
               state_n = S_CP_RD;
            end
         end
         S_FIN:   state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Memory port decode from state and latched command.
   always_comb begin
      mem_addr   = 8'd0;
      mem_wr_en  = 1'b0;
      mem_dat_in = 8'd0;
      unique case (state)
         S_EXEC: begin
            unique case (op_q)
               OP_LOAD: begin
                  mem_addr = addr_q;
               end
               OP_STORE: begin
                  mem_addr   = addr_q;
                  mem_wr_en  = 1'b1;
                  mem_dat_in = wdata_q;
               end
               OP_PUSH: begin
                  mem_addr   = sp;
                  mem_wr_en  = !full;
                  mem_dat_in = wdata_q;
               end
               OP_POP: begin
                  mem_addr = sp + 8'd1;
               end
               default: ;
            endcase
         end
         S_CP_RD: begin
            mem_addr = src_ptr;
         end
         S_CP_WR: begin
            mem_addr   = dst_ptr;
            mem_wr_en  = 1'b1;
            mem_dat_in = cbuf_q;
         end
         default: ;
      endcase
   end

   // Command latch, read capture and copy pointers.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q    <= OP_LOAD;
         addr_q  <= 8'd0;
         wdata_q <= 8'd0;
         src_ptr <= 8'd0;
         dst_ptr <= 8'd0;
         cnt     <= 8'd0;
         cbuf_q  <= 8'd0;
         err_q   <= 1'b0;
         rdata   <= 8'd0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  op_q    <= op_t'(op);
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  src_ptr <= src;
                  dst_ptr <= addr;
                  cnt     <= len;
                  err_q   <= !op_defined(op);
               end
            end
            S_EXEC: begin
               if (op_q == OP_LOAD) begin
                  rdata <= mem_dat_out;
               end
               if (op_q == OP_POP) begin
                  if (empty) begin
                     err_q <= 1'b1;
                  end else begin
                     rdata <= mem_dat_out;
                  end
               end
               if (op_q == OP_PUSH && full) begin
                  err_q <= 1'b1;
               end
            end
            S_CP_RD: begin
               cbuf_q <= mem_dat_out;
            end
            S_CP_WR: begin
               src_ptr <= src_ptr + 8'd1;
               dst_ptr <= dst_ptr + 8'd1;
               cnt     <= cnt - 8'd1;
            end
            default: ;
         endcase
      end
   end

endmodule
